// File: rtl/perceptron_trainer_if.sv
// Handshake, result and readback bundle for perceptron_trainer.
//   master (vector source / debug): in_valid, x, exp_res, train, threshold, rd_idx
//   slave  (perceptron):            in_ready, out_valid, result, sum, mistakes, rd_weight
// IDX_W / ACC_W here must track the same localparams in perceptron_trainer.
interface perceptron_trainer_if #(
  parameter int N_IN    = 7,
  parameter int W_WIDTH = 8
);
  localparam int IDX_W = ($clog2(N_IN + 1) > 1) ? $clog2(N_IN + 1) : 1;
  localparam int ACC_W = W_WIDTH + IDX_W + 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [N_IN-1:0]         x;
  logic                    exp_res;
  logic                    train;
  logic signed [ACC_W-1:0] threshold;
  logic                    out_valid;
  logic [1:0]              result;
  logic signed [ACC_W-1:0] sum;
  logic [15:0]             mistakes;
  logic [IDX_W-1:0]        rd_idx;
  logic [W_WIDTH-1:0]      rd_weight;

  modport master (
    output in_valid, x, exp_res, train, threshold, rd_idx,
    input  in_ready, out_valid, result, sum, mistakes, rd_weight
  );

  modport slave (
    input  in_valid, x, exp_res, train, threshold, rd_idx,
    output in_ready, out_valid, result, sum, mistakes, rd_weight
  );
endinterface

// File: rtl/perceptron_trainer.sv
// Serially evaluated perceptron with on-line saturating training.
// One input term is accumulated per cycle (ACCUM), the sum is compared to a
// signed threshold (DECIDE), and on a training misprediction each active
// weight is stepped by +/-(1<<LR_SHIFT) with saturation (UPDATE).
// Ports:
//   clk   - clock
//   reset - synchronous active-low reset
//   bus   - perceptron_trainer_if.slave: valid/ready vector input, +/-1
//           result, net sum, mistake counter, combinational weight readback
// Optional: define PERCEPTRON_BIAS_EN to add a bias weight at index N_IN with
// constant input 1 (ACCUM/UPDATE then take N_IN+1 cycles).
module perceptron_trainer #(
  parameter int N_IN     = 7,
  parameter int W_WIDTH  = 8,
  parameter int LR_SHIFT = 0
) (
  input logic                 clk,
  input logic                 reset,
  perceptron_trainer_if.slave bus
);
  localparam int IDX_W = ($clog2(N_IN + 1) > 1) ? $clog2(N_IN + 1) : 1;
  localparam int ACC_W = W_WIDTH + IDX_W + 1;
`ifdef PERCEPTRON_BIAS_EN
  localparam int NW = N_IN + 1;
`else
  localparam int NW = N_IN;
`endif
  localparam logic [IDX_W-1:0]   LAST  = IDX_W'(NW - 1);
  localparam logic [W_WIDTH:0]   STEP  = (W_WIDTH + 1)'(1 << LR_SHIFT);
  localparam logic [W_WIDTH-1:0] W_MAX = {1'b0, {(W_WIDTH-1){1'b1}}};
  localparam logic [W_WIDTH-1:0] W_MIN = {1'b1, {(W_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DECIDE, S_UPDATE} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] thr_q;
  logic [N_IN-1:0]         x_q;
  logic                    exp_q, train_q;
  logic signed [ACC_W-1:0] sum_q;
  logic [1:0]              result_q;
  logic                    out_valid_q;
  logic [15:0]             mistakes_q;
  logic [W_WIDTH-1:0]      w_q [NW];

  // Effective input vector; the bias lane always sees a 1.
  logic [NW-1:0] xb;
`ifdef PERCEPTRON_BIAS_EN
  assign xb = {1'b1, x_q};
`else
  assign xb = x_q;
`endif

  // Lane selected by idx_q (shared by ACCUM and UPDATE).
  logic [W_WIDTH-1:0] w_sel;
  logic               x_sel;
  always_comb begin
    w_sel = '0;
    x_sel = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_sel = w_q[i];
        x_sel = xb[i];
      end
    end
  end

  // Out-of-range indices read as 0 (covers rd_idx=N_IN without bias).
  always_comb begin
    bus.rd_weight = '0;
    for (int i = 0; i < NW; i++) begin
      if (bus.rd_idx == IDX_W'(i)) bus.rd_weight = w_q[i];
    end
  end

  logic signed [ACC_W-1:0] term;
  assign term = x_sel ? {{(ACC_W-W_WIDTH){w_sel[W_WIDTH-1]}}, w_sel} : '0;

  logic pred_pos, mispred;
  assign pred_pos = (acc_q >= thr_q);
  assign mispred  = (pred_pos != exp_q);

  // One guard bit catches overflow: STEP < 2^(W_WIDTH-1) so the sum can only
  // leave the range by one wrap, and bits [W] vs [W-1] disagree exactly then.
  logic [W_WIDTH:0]   w_sum;
  logic [W_WIDTH-1:0] w_new;
  always_comb begin
    w_sum = exp_q ? ({w_sel[W_WIDTH-1], w_sel} + STEP)
                  : ({w_sel[W_WIDTH-1], w_sel} - STEP);
    if (w_sum[W_WIDTH] != w_sum[W_WIDTH-1]) w_new = w_sum[W_WIDTH] ? W_MIN : W_MAX;
    else                                    w_new = w_sum[W_WIDTH-1:0];
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.in_valid)       state_d = S_ACCUM;
      S_ACCUM:  if (idx_q == LAST)      state_d = S_DECIDE;
      S_DECIDE: state_d = (train_q && mispred) ? S_UPDATE : S_IDLE;
      S_UPDATE: if (idx_q == LAST)      state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs / datapath enables
  logic cap_en, acc_en, dec_en, upd_en;
  always_comb begin
    bus.in_ready = (state_q == S_IDLE);
    cap_en       = (state_q == S_IDLE) && bus.in_valid;
    acc_en       = (state_q == S_ACCUM);
    dec_en       = (state_q == S_DECIDE);
    upd_en       = (state_q == S_UPDATE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q       <= '0;
      acc_q       <= '0;
      thr_q       <= '0;
      x_q         <= '0;
      exp_q       <= 1'b0;
      train_q     <= 1'b0;
      sum_q       <= '0;
      result_q    <= 2'b00;
      out_valid_q <= 1'b0;
      mistakes_q  <= '0;
    end else begin
      out_valid_q <= dec_en;
      if (cap_en) begin
        x_q     <= bus.x;
        exp_q   <= bus.exp_res;
        train_q <= bus.train;
        thr_q   <= bus.threshold;
        acc_q   <= '0;
        idx_q   <= '0;
      end
      if (acc_en) begin
        acc_q <= acc_q + term;
        idx_q <= (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
      end
      if (dec_en) begin
        sum_q    <= acc_q;
        result_q <= pred_pos ? 2'b01 : 2'b11;
        idx_q    <= '0;
        if (train_q && mispred && mistakes_q != 16'hFFFF)
          mistakes_q <= mistakes_q + 16'd1;
      end
      if (upd_en) idx_q <= idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NW; i++) begin
      if (!reset)                                        w_q[i] <= '0;
      else if (upd_en && idx_q == IDX_W'(i) && xb[i])    w_q[i] <= w_new;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.sum       = sum_q;
  assign bus.mistakes  = mistakes_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench: u_a is the default 7x8-bit build, u_b a 4-bit weight /
// LR_SHIFT=2 build used for saturation. Both share clock and reset.
module tb_perceptron_trainer;
`ifdef PERCEPTRON_BIAS_EN
  localparam int BIAS = 1;
`else
  localparam int BIAS = 0;
`endif
  localparam int LAT = 9 + BIAS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  perceptron_trainer_if #(.N_IN(7), .W_WIDTH(8)) ia ();
  perceptron_trainer_if #(.N_IN(7), .W_WIDTH(4)) ib ();

  perceptron_trainer #(.N_IN(7), .W_WIDTH(8), .LR_SHIFT(0)) u_a (
    .clk(clk), .reset(reset), .bus(ia));
  perceptron_trainer #(.N_IN(7), .W_WIDTH(4), .LR_SHIFT(2)) u_b (
    .clk(clk), .reset(reset), .bus(ib));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic send_a(input logic [6:0] xv, input logic e, input logic tr,
                        input int thr, output int lat);
    @(negedge clk);
    ia.x = xv; ia.exp_res = e; ia.train = tr; ia.threshold = 12'(thr); ia.in_valid = 1'b1;
    @(posedge clk);
    #1 ia.in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ia.out_valid) begin lat = k; break; end
    end
  endtask

  task automatic send_b(input logic [6:0] xv, input logic e, input logic tr,
                        input int thr, output int lat);
    @(negedge clk);
    ib.x = xv; ib.exp_res = e; ib.train = tr; ib.threshold = 8'(thr); ib.in_valid = 1'b1;
    @(posedge clk);
    #1 ib.in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ib.out_valid) begin lat = k; break; end
    end
  endtask

  task automatic wait_idle_a();
    for (int k = 0; k < 40 && !ia.in_ready; k++) @(negedge clk);
    chk("a_ready", 64'(ia.in_ready), 64'(1));
  endtask

  task automatic wait_idle_b();
    for (int k = 0; k < 40 && !ib.in_ready; k++) @(negedge clk);
    chk("b_ready", 64'(ib.in_ready), 64'(1));
  endtask

  task automatic chk_wa(input string tag, input int idx, input int exp);
    ia.rd_idx = 3'(idx);
    #1;
    chk(tag, 64'($signed(ia.rd_weight)), 64'(exp));
  endtask

  initial begin
    int lat;
    int hi;
    int sb [3];
    int wb [3];
    reset = 1'b0;
    ia.in_valid = 1'b0; ia.x = '0; ia.exp_res = 1'b0; ia.train = 1'b0;
    ia.threshold = '0; ia.rd_idx = '0;
    ib.in_valid = 1'b0; ib.x = '0; ib.exp_res = 1'b0; ib.train = 1'b0;
    ib.threshold = '0; ib.rd_idx = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);

    // Reset defaults
    chk("rst_ready",  64'(ia.in_ready), 64'(1));
    chk("rst_result", 64'(ia.result), 64'(2'b00));
    chk("rst_mist",   64'(ia.mistakes), 64'(0));
    chk("rst_ovalid", 64'(ia.out_valid), 64'(0));
    chk("rst_sum",    64'($signed(ia.sum)), 64'(0));
    for (int i = 0; i < 8; i++) chk_wa("rst_w", i, 0);

    // Inference, all inputs set, zero weights
    send_a(7'h7F, 1'b1, 1'b0, 0, lat);
    chk("inf_lat",    64'(lat), 64'(LAT));
    chk("inf_sum",    64'($signed(ia.sum)), 64'(0));
    chk("inf_result", 64'(ia.result), 64'(2'b01));
    @(negedge clk);
    chk("inf_pulse",  64'(ia.out_valid), 64'(0));
    chk("inf_hold",   64'(ia.result), 64'(2'b01));
    chk("inf_mist",   64'(ia.mistakes), 64'(0));
    chk_wa("inf_w3", 3, 0);

    // Training step: predicted +1, expected -1
    send_a(7'b0000101, 1'b0, 1'b1, 0, lat);
    chk("tr1_lat",    64'(lat), 64'(LAT));
    chk("tr1_result", 64'(ia.result), 64'(2'b01));
    chk("tr1_mist",   64'(ia.mistakes), 64'(1));
    wait_idle_a();
    for (int i = 0; i < 8; i++)
      chk_wa("tr1_w", i, (i == 0 || i == 2 || (i == 7 && BIAS == 1)) ? -1 : 0);

    // Same vector again: now correct, no update
    send_a(7'b0000101, 1'b0, 1'b1, 0, lat);
    chk("tr2_sum",    64'($signed(ia.sum)), 64'(-2 - BIAS));
    chk("tr2_result", 64'(ia.result), 64'(2'b11));
    wait_idle_a();
    chk("tr2_mist",   64'(ia.mistakes), 64'(1));

    // Reset during third UPDATE cycle
    send_a(7'h7F, 1'b1, 1'b1, 0, lat);
    chk("mid_result", 64'(ia.result), 64'(2'b11));
    chk("mid_mist",   64'(ia.mistakes), 64'(2));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_wa("mid_w0", 0, 0);
    chk_wa("mid_w1", 1, 1);
    chk_wa("mid_w2", 2, -1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mrst_ready",  64'(ia.in_ready), 64'(1));
    chk("mrst_ovalid", 64'(ia.out_valid), 64'(0));
    chk("mrst_mist",   64'(ia.mistakes), 64'(0));
    chk("mrst_result", 64'(ia.result), 64'(2'b00));
    for (int i = 0; i < 8; i++) chk_wa("mrst_w", i, 0);
    hi = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ia.out_valid) hi++;
    end
    chk("mrst_quiet", 64'(hi), 64'(0));

`ifdef PERCEPTRON_BIAS_EN
    // Bias learns the threshold for an all-zero input
    send_a(7'h00, 1'b1, 1'b1, 1, lat);
    chk("bias1_lat",    64'(lat), 64'(10));
    chk("bias1_result", 64'(ia.result), 64'(2'b11));
    wait_idle_a();
    chk_wa("bias1_w", 7, 1);
    send_a(7'h00, 1'b1, 1'b1, 1, lat);
    chk("bias2_lat",    64'(lat), 64'(10));
    chk("bias2_sum",    64'($signed(ia.sum)), 64'(1));
    chk("bias2_result", 64'(ia.result), 64'(2'b01));
    chk("bias2_mist",   64'(ia.mistakes), 64'(1));
`else
    // All-zero input: threshold alone decides, mistake counted, no weight moves
    send_a(7'h00, 1'b0, 1'b1, 0, lat);
    chk("zero1_lat",    64'(lat), 64'(9));
    chk("zero1_sum",    64'($signed(ia.sum)), 64'(0));
    chk("zero1_result", 64'(ia.result), 64'(2'b01));
    chk("zero1_mist",   64'(ia.mistakes), 64'(1));
    wait_idle_a();
    for (int i = 0; i < 8; i++) chk_wa("zero1_w", i, 0);
    send_a(7'h00, 1'b0, 1'b1, 1, lat);
    chk("zero2_result", 64'(ia.result), 64'(2'b11));
    chk("zero2_mist",   64'(ia.mistakes), 64'(1));
`endif

    // Saturation: 4-bit weights, step 4, threshold at max positive
    sb[0] = 0; sb[1] = 4 * (1 + BIAS); sb[2] = 7 * (1 + BIAS);
    wb[0] = 4; wb[1] = 7; wb[2] = 7;
    for (int r = 0; r < 3; r++) begin
      send_b(7'h01, 1'b1, 1'b1, 127, lat);
      chk("sat_lat",    64'(lat), 64'(LAT));
      chk("sat_sum",    64'($signed(ib.sum)), 64'(sb[r]));
      chk("sat_result", 64'(ib.result), 64'(2'b11));
      wait_idle_b();
      ib.rd_idx = 3'd0;
      #1;
      chk("sat_w0", 64'($signed(ib.rd_weight)), 64'(wb[r]));
    end
    chk("sat_mist", 64'(ib.mistakes), 64'(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
